// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one synchronous FIFO write
// port among N_REQ producers. Grants are combinational (zero latency) and
// are suppressed whenever fifo_full is high or rst is asserted.
// Optional burst holding is compiled in with `define FIFO_ARB_BURST_EN;
// without it the arbiter is a plain single-grant round robin and busy is 0.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_MAX = 4,
  localparam int unsigned IDX_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    fifo_full,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_din,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy
);

  // Reject parameter values outside the supported range at elaboration.
  if (N_REQ < 2 || N_REQ > 16 || BURST_MAX < 1 || BURST_MAX > 255 || DATA_W < 1)
  begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  logic [IDX_W-1:0] prio_q, prio_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] scan_start;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [N_REQ-1:0] grant_vec;

  // Index + 1 with wrap at N_REQ-1.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (32'(i) == N_REQ - 1) return '0;
    else                     return i + 1'b1;
  endfunction

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic {IDLE, LOCK} state_t;

  localparam logic [7:0] BMAX = 8'(BURST_MAX);

  state_t     st_q, st_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       hold;

  // In LOCK the scan is only used on release, so it starts after the owner.
  assign scan_start = (st_q == LOCK) ? next_idx(owner_q) : prio_q;
`else
  assign scan_start = prio_q;
`endif

  // Round-robin scan: first requester at or after scan_start wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((32'(scan_start) + k) % N_REQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Grant decision and next-state; a reset or full cycle leaves state untouched.
  always_comb begin
    grant_vec = '0;
    prio_d    = prio_q;
    owner_d   = owner_q;
`ifdef FIFO_ARB_BURST_EN
    st_d      = st_q;
    bcnt_d    = bcnt_q;
    hold      = 1'b0;
    if (!rst && !fifo_full) begin
      if (st_q == LOCK && req[owner_q]) begin
        grant_vec[owner_q] = 1'b1;
        bcnt_d             = bcnt_q + 8'd1;
        if (bcnt_d == BMAX) begin
          prio_d = next_idx(owner_q);
          st_d   = IDLE;
        end
      end else if (win_found) begin
        grant_vec[win_idx] = 1'b1;
        owner_d            = win_idx;
        if (st_q == LOCK) begin
          // Owner dropped its request: release and hand this cycle to the
          // next requester as a single grant; it may lock on its next turn.
          prio_d = next_idx(owner_q);
          st_d   = IDLE;
        end else if (BURST_MAX > 1) begin
          st_d   = LOCK;
          bcnt_d = 8'd1;
          hold   = 1'b1;
        end else begin
          prio_d = next_idx(win_idx);
        end
      end else if (st_q == LOCK) begin
        prio_d = next_idx(owner_q);
        st_d   = IDLE;
      end
    end
`else
    if (!rst && !fifo_full && win_found) begin
      grant_vec[win_idx] = 1'b1;
      owner_d            = win_idx;
      prio_d             = next_idx(win_idx);
    end
`endif
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q  <= '0;
      owner_q <= '0;
`ifdef FIFO_ARB_BURST_EN
      st_q    <= IDLE;
      bcnt_q  <= '0;
`endif
    end else begin
      prio_q  <= prio_d;
      owner_q <= owner_d;
`ifdef FIFO_ARB_BURST_EN
      st_q    <= st_d;
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  // Write data mux: slice of the granted producer, zero when idle.
  always_comb begin
    fifo_din = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_vec[i]) fifo_din = fifo_din | data[i*DATA_W +: DATA_W];
    end
  end

  assign gnt        = grant_vec;
  assign fifo_wr_en = |grant_vec;
  assign owner      = owner_q;

`ifdef FIFO_ARB_BURST_EN
  // Busy marks cycles in which the port is held by a burst: the grant that
  // opens a lock, and every LOCK cycle (including full stalls) while the
  // owner keeps requesting. A releasing cycle reads 0.
  assign busy = !rst && ((st_q == LOCK && req[owner_q]) || (st_q == IDLE && hold));
`else
  assign busy = 1'b0;
`endif

endmodule
